// File: rtl/conn40_capture.sv
// 40-pin connector receive side: 2-flop sync, whole-bus filter, timestamped FWFT event FIFO.
// Optional CONN40_MASK_EN adds MASK: masked-only changes update STATE without an event.
module conn40_capture #(
  parameter int FILT  = 4,
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
`ifdef CONN40_MASK_EN
  input  logic [40:1]     MASK,
`endif
  input  logic            CLK,
  input  logic            RESET,
  input  logic [40:1]     PIN_IN,
  output logic [40:1]     STATE,
  output logic [40:1]     EVT_DATA,
  output logic [TS_W-1:0] EVT_TIME,
  output logic            EVT_VALID,
  input  logic            EVT_READY,
  output logic            OVERFLOW,
  input  logic            CLR_OVF
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW = 40 + TS_W;

  logic [40:1]     r_s1;
  logic [40:1]     r_s2;
  logic [40:1]     r_state;
  logic [3:0]      r_cnt;
  logic [TS_W-1:0] r_ts;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_num;
  logic            r_ovf;

  logic w_chg;
  logic w_hit;
  logic w_evt;
  logic w_pop;
  logic w_full;
  logic w_drop;
  logic w_push;

  // The run restarts on the edge a new value enters S2, so CNT counts
  // cycles that S2 has already held its current value.
  assign w_chg = (r_s1 != r_s2);
  assign w_hit = (r_cnt == 4'(FILT - 1)) && (r_s2 != r_state);

`ifdef CONN40_MASK_EN
  assign w_evt = w_hit && (((r_s2 ^ r_state) & ~MASK) != '0);
`else
  assign w_evt = w_hit;
`endif

  assign w_pop  = (r_num != '0) && EVT_READY;
  assign w_full = (r_num == (AW+1)'(DEPTH));
  assign w_drop = w_evt && w_full && !w_pop;
  assign w_push = w_evt && !w_drop;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_state <= '0;
      r_cnt   <= '0;
      r_ts    <= '0;
    end else begin
      r_s1 <= PIN_IN;
      r_s2 <= r_s1;
      r_ts <= r_ts + 1'b1;
      if (w_chg)
        r_cnt <= '0;
      else if (r_cnt != 4'(FILT))
        r_cnt <= r_cnt + 4'd1;
      if (w_hit)
        r_state <= r_s2;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_num <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)
        r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_num <= r_num + 1'b1;
        2'b01:   r_num <= r_num - 1'b1;
        default: r_num <= r_num;
      endcase
      if (w_drop)
        r_ovf <= 1'b1;
      else if (CLR_OVF)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && w_push)
      r_mem[r_wp] <= {r_s2, r_ts};
  end

  assign STATE     = r_state;
  assign EVT_DATA  = r_mem[r_rp][DW-1:TS_W];
  assign EVT_TIME  = r_mem[r_rp][TS_W-1:0];
  assign EVT_VALID = (r_num != '0);
  assign OVERFLOW  = r_ovf;

endmodule

// File: tb/tb_conn40_capture.sv
// Random + directed bench for conn40_capture against a run-length/queue model.
// Default build (no mask feature).
module tb_conn40_capture;

  localparam int FILT  = 4;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [40:1] PIN_IN;
  logic [40:1] STATE;
  logic [40:1] EVT_DATA;
  logic [15:0] EVT_TIME;
  logic        EVT_VALID;
  logic        EVT_READY;
  logic        OVERFLOW;
  logic        CLR_OVF;

  always #5 CLK = ~CLK;

  conn40_capture #(.FILT(FILT), .DEPTH(DEPTH), .TS_W(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PIN_IN    (PIN_IN),
    .STATE     (STATE),
    .EVT_DATA  (EVT_DATA),
    .EVT_TIME  (EVT_TIME),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .OVERFLOW  (OVERFLOW),
    .CLR_OVF   (CLR_OVF)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_s1 is the last sampled pin value, m_v the synchronized value
  // and m_run how many cycles m_v has held.
  logic [40:1] m_s1;
  logic [40:1] m_v;
  logic [40:1] m_state;
  int          m_run;
  logic [15:0] m_ts;
  logic        m_ovf;
  logic [55:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [40:1] pin, input logic rdy,
                            input logic clr, input logic rst);
    logic commit, pop, drop;
    if (rst) begin
      m_s1 = '0; m_v = '0; m_run = 1; m_state = '0;
      m_ts = '0; m_ovf = 1'b0; q.delete();
      return;
    end
    commit = (m_run == FILT) && (m_v != m_state);
    pop    = (q.size() != 0) && rdy;
    drop   = commit && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (commit && !drop) q.push_back({m_v, m_ts});
    if (commit) m_state = m_v;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (m_s1 != m_v) m_run = 1;
    else m_run++;
    m_v  = m_s1;
    m_s1 = pin;
    m_ts = m_ts + 16'd1;
  endtask

  task automatic step(input logic [40:1] pin, input logic rdy,
                      input logic clr, input logic rst);
    PIN_IN = pin; EVT_READY = rdy; CLR_OVF = clr; RESET = rst;
    @(posedge CLK);
    model_edge(pin, rdy, clr, rst);
    @(negedge CLK);
    chk("state", STATE, m_state);
    chk("valid", EVT_VALID, q.size() != 0);
    chk("ovf", OVERFLOW, m_ovf);
    if (q.size() != 0) begin
      chk("data", EVT_DATA, q[0][55:16]);
      chk("time", EVT_TIME, q[0][15:0]);
    end
  endtask

  task automatic hold(input logic [40:1] pin, input int n,
                      input logic rdy, input logic clr);
    for (int i = 0; i < n; i++) step(pin, rdy, clr, 1'b0);
  endtask

  logic [40:1] pool [4];
  logic [40:1] pat;
  int          n;

  initial begin
    PIN_IN = '0; EVT_READY = 0; CLR_OVF = 0; RESET = 1;
    @(negedge CLK);
    step('0, 0, 0, 1);
    chk("rst_state", STATE, 0);
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_ovf", OVERFLOW, 0);
    hold('0, 8, 0, 0);

    n = 0;
    do begin
      step(40'h1, 0, 0, 0);
      n++;
    end while (STATE != 40'h1 && n < 20);
    chk("latency", n, FILT + 2);
    chk("lat_data", EVT_DATA, 40'h1);
    step(40'h1, 1, 0, 0);
    chk("pop_valid", EVT_VALID, 0);

    hold('0, 8, 1, 0);
    hold(40'h1, 3, 0, 0);
    hold('0, 10, 0, 0);
    chk("glitch_valid", EVT_VALID, 0);
    chk("glitch_state", STATE, 0);
    hold(40'h1, 4, 0, 0);
    hold('0, 10, 0, 0);
    chk("pulse_head", EVT_DATA, 40'h1);
    step('0, 1, 0, 0);
    chk("pulse_2nd", EVT_DATA, 40'h0);
    hold('0, 3, 1, 0);

    for (int i = 0; i < 5; i++) hold(40'h10 << i, 6, 0, 0);
    chk("ovf_set", OVERFLOW, 1);
    chk("ovf_head", EVT_DATA, 40'h10);
    step(40'h100, 0, 1, 0);
    chk("ovf_clr", OVERFLOW, 0);
    hold(40'h2000, 6, 0, 1);
    chk("ovf_setwins", OVERFLOW, 1);
    step(40'h2000, 0, 1, 0);
    hold(40'h2000, 5, 1, 0);

    for (int i = 0; i < 4; i++) hold(40'h3 << i, 6, 0, 0);
    hold(40'h7777, 5, 0, 0);
    step(40'h7777, 1, 0, 0);
    chk("full_pp_ovf", OVERFLOW, 0);
    hold(40'h7777, 3, 1, 0);
    chk("full_pp_last", EVT_DATA, 40'h7777);
    step(40'h7777, 1, 0, 0);
    chk("drained", EVT_VALID, 0);

    for (int i = 0; i < 3; i++) hold(40'h500 << i, 6, 0, 0);
    step(40'h0, 0, 0, 1);
    chk("rst_mid_valid", EVT_VALID, 0);
    chk("rst_mid_state", STATE, 0);

    pool[0] = '0;
    pool[1] = 40'h1;
    for (int r = 0; r < 400; r++) begin
      if ((r % 50) == 0) begin
        pool[2] = {$urandom(), $urandom()};
        pool[3] = {$urandom(), $urandom()};
      end
      pat = pool[$urandom_range(0, 3)];
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++)
        step(pat, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
